// File: rtl/led_cube_frame_driver_if.sv
// Frame driver bus: scan control, frame fetch, latch/layer drive, pulse.
// Design side is master; the surrounding logic is slave.
interface led_cube_frame_driver_if;
   logic       start;
   logic       stop;
   logic       done;
   logic [5:0] addr;
   logic [7:0] data_to_latch;
   logic [7:0] Layers;
   logic [7:0] Latches;
   logic [7:0] Data;
   logic       cond;
   logic       pulse;

   modport master (
      input  start, stop, data_to_latch, cond,
      output done, addr, Layers, Latches, Data, pulse
   );

   modport slave (
      output start, stop, data_to_latch, cond,
      input  done, addr, Layers, Latches, Data, pulse
   );
endinterface

// File: rtl/led_cube_frame_driver.sv
// 8x8x8 LED cube scan engine: loads column latches per layer, then
// lights that layer for LAYER_HOLD cycles. Includes a rising-edge pulser.
module led_cube_frame_driver #(
   parameter int LAYER_HOLD = 6250
) (
   input logic                    clk,
   input logic                    rst_n,
   led_cube_frame_driver_if.master bus
);
   localparam int HW = (LAYER_HOLD > 1) ? $clog2(LAYER_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(LAYER_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, STROBE, HOLD, DISPLAY
   } state_t;

   state_t          state, state_n;
   logic [2:0]      layer, layer_n;
   logic [2:0]      col, col_n;
   logic [HW-1:0]   hold, hold_n;
   logic [7:0]      data_q, data_n;
   logic            cond_q, pulse_q;
   logic            done_c;
   logic [5:0]      addr_c;
   logic [7:0]      layers_c, latches_c;

   // State and scan counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         layer  <= '0;
         col    <= '0;
         hold   <= '0;
         data_q <= '0;
      end else begin
         state  <= state_n;
         layer  <= layer_n;
         col    <= col_n;
         hold   <= hold_n;
         data_q <= data_n;
      end
   end

   // Next-state logic; stop beats start, start restarts from layer 0
   always_comb begin
      state_n = state;
      layer_n = layer;
      col_n   = col;
      hold_n  = hold;
      data_n  = data_q;
      if (bus.stop) begin
         state_n = IDLE;
         layer_n = '0;
         col_n   = '0;
         hold_n  = '0;
         data_n  = '0;
      end else if (bus.start) begin
         state_n = SETUP;
         layer_n = '0;
         col_n   = '0;
         hold_n  = '0;
      end else begin
         unique case (state)
            IDLE: ;
            SETUP: begin
               data_n  = bus.data_to_latch;
               state_n = STROBE;
            end
            STROBE: state_n = HOLD;
            HOLD: begin
               if (col == 3'd7) begin
                  col_n   = '0;
                  hold_n  = '0;
                  state_n = DISPLAY;
               end else begin
                  col_n   = col + 3'd1;
                  state_n = SETUP;
               end
            end
            DISPLAY: begin
               if (hold == HOLD_LAST) begin
                  layer_n = layer + 3'd1;
                  state_n = SETUP;
               end else begin
                  hold_n = hold + HW'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Output decode from registered state only; layers blank while loading
   always_comb begin
      addr_c    = (state == IDLE) ? 6'd0 : {layer, col};
      layers_c  = (state == DISPLAY) ? (8'd1 << layer) : 8'd0;
      latches_c = (state == STROBE) ? (8'd1 << col) : 8'd0;
      done_c    = (state == DISPLAY) && (layer == 3'd7) &&
                  (hold == HOLD_LAST);
   end

   // Rising-edge pulse generator, independent of the scan
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cond_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         cond_q  <= bus.cond;
         pulse_q <= bus.cond & ~cond_q;
      end
   end

   assign bus.addr    = addr_c;
   assign bus.Layers  = layers_c;
   assign bus.Latches = latches_c;
   assign bus.done    = done_c;
   assign bus.Data    = data_q;
   assign bus.pulse   = pulse_q;
endmodule

// File: tb/tb_led_cube_frame_driver.sv
// Scoreboard bench for the LED cube frame driver (LAYER_HOLD = 4).
// Stimulus queues expected outputs per cycle; a negedge monitor checks.
module tb_led_cube_frame_driver;
   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_cube_frame_driver_if bus ();

   led_cube_frame_driver #(.LAYER_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.data_to_latch = {2'b00, bus.addr} + 8'h10;

   typedef struct {
      int         cyc;
      string      nm;
      bit         is_pulse;
      logic [7:0] lay;
      logic [7:0] lat;
      logic [5:0] ad;
      logic       dn;
      bit         cd;
      logic [7:0] dat;
      logic       pl;
   } exp_t;

   exp_t sb[$];

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h",
                  nm, cyc, act, req);
      end
   endfunction

   task automatic exp_scan(int c, string nm, logic [7:0] lay,
                           logic [7:0] lat, logic [5:0] ad, logic dn,
                           bit cd, logic [7:0] dat);
      exp_t e;
      e.cyc = c; e.nm = nm; e.is_pulse = 1'b0;
      e.lay = lay; e.lat = lat; e.ad = ad; e.dn = dn;
      e.cd = cd; e.dat = dat; e.pl = 1'b0;
      sb.push_back(e);
   endtask

   task automatic exp_pulse(int c, string nm, logic pl);
      exp_t e;
      e.cyc = c; e.nm = nm; e.is_pulse = 1'b1;
      e.lay = '0; e.lat = '0; e.ad = '0; e.dn = 1'b0;
      e.cd = 1'b0; e.dat = '0; e.pl = pl;
      sb.push_back(e);
   endtask

   // Monitor: pop and compare every expectation due this cycle
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         if (e.cyc < cyc)
            chk({e.nm, "_missed"}, 32'(cyc), 32'(e.cyc));
         else if (e.is_pulse)
            chk(e.nm, 32'(bus.pulse), 32'(e.pl));
         else if (e.cd)
            chk(e.nm,
                {bus.Layers, bus.Latches, bus.addr, bus.done, bus.Data[7:1]},
                {e.lay, e.lat, e.ad, e.dn, e.dat[7:1]});
         else
            chk(e.nm, {8'h0, bus.Layers, bus.Latches, bus.addr, bus.done},
                {8'h0, e.lay, e.lat, e.ad, e.dn});
         if (!e.is_pulse && e.cd)
            chk({e.nm, "_d0"}, 32'(bus.Data[0]), 32'(e.dat[0]));
      end
   end

   // Event counters over a full two-scan window
   bit cnt_en = 1'b0;
   int cnt_done = 0, cnt_lat = 0, cnt_bad = 0;
   always @(negedge clk) begin
      if (cnt_en) begin
         if (bus.done) cnt_done++;
         if (bus.Latches != 8'h0) cnt_lat++;
         if (bus.Latches != 8'h0 && !$onehot(bus.Latches)) cnt_bad++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(int c);
      while (cyc < c) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   int t;
   bit         csched [14] = '{0,0,0,1,1,1,1,1,0,0,1,0,0,0};
   logic       pexp   [14] = '{0,0,0,0,1,0,0,0,0,0,0,1,0,0};

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.cond = 1'b0;
      step();
      step();
      exp_scan(cyc, "reset", 8'h00, 8'h00, 6'd0, 1'b0, 1'b1, 8'h00);
      exp_pulse(cyc, "reset_pulse", 1'b0);
      rst_n = 1'b1;
      step();

      // Load order and full scans
      t = cyc;
      bus.start = 1'b1;
      cnt_en = 1'b1;
      exp_scan(t + 1, "setup0", 8'h00, 8'h00, 6'd0, 1'b0, 1'b1, 8'h00);
      exp_scan(t + 2, "strobe0", 8'h00, 8'h01, 6'd0, 1'b0, 1'b1, 8'h10);
      exp_scan(t + 5, "strobe1", 8'h00, 8'h02, 6'd1, 1'b0, 1'b1, 8'h11);
      exp_scan(t + 24, "hold7", 8'h00, 8'h00, 6'd7, 1'b0, 1'b1, 8'h17);
      for (int k = 25; k <= 28; k++)
         exp_scan(t + k, "disp0", 8'h01, 8'h00, 6'd0, 1'b0, 1'b1, 8'h17);
      exp_scan(t + 29, "setup_l1", 8'h00, 8'h00, 6'd8, 1'b0, 1'b0, 8'h0);
      for (int l = 1; l < 8; l++)
         exp_scan(t + 25 + 28 * l, "disp_seq", 8'h01 << l, 8'h00,
                  6'(8 * l), 1'b0, 1'b0, 8'h0);
      exp_scan(t + 223, "pre_done", 8'h80, 8'h00, 6'h38, 1'b0, 1'b1, 8'h4f);
      exp_scan(t + 224, "done1", 8'h80, 8'h00, 6'h38, 1'b1, 1'b1, 8'h4f);
      exp_scan(t + 225, "post_done", 8'h00, 8'h00, 6'd0, 1'b0, 1'b0, 8'h0);
      exp_scan(t + 448, "done2", 8'h80, 8'h00, 6'h38, 1'b1, 1'b1, 8'h4f);
      step();
      bus.start = 1'b0;
      wait_to(t + 449);
      cnt_en = 1'b0;
      chk("done_count", 32'(cnt_done), 32'd2);
      chk("strobe_count", 32'(cnt_lat), 32'd128);
      chk("strobe_onehot", 32'(cnt_bad), 32'd0);

      // Stop during layer 3 display, then start+stop together
      t = cyc;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      exp_scan(t + 110, "disp3", 8'h08, 8'h00, 6'h18, 1'b0, 1'b0, 8'h0);
      exp_scan(t + 111, "stopped", 8'h00, 8'h00, 6'd0, 1'b0, 1'b1, 8'h00);
      wait_to(t + 110);
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      wait_to(t + 113);
      bus.start = 1'b1;
      bus.stop = 1'b1;
      exp_scan(t + 114, "start_stop", 8'h00, 8'h00, 6'd0, 1'b0, 1'b1, 8'h00);
      exp_scan(t + 116, "still_idle", 8'h00, 8'h00, 6'd0, 1'b0, 1'b1, 8'h00);
      step();
      bus.start = 1'b0;
      bus.stop = 1'b0;
      wait_to(t + 117);

      // Restart during layer 5 load
      t = cyc;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      exp_scan(t + 150, "l5_load", 8'h00, 8'h00, 6'h2b, 1'b0, 1'b0, 8'h0);
      exp_scan(t + 151, "restart", 8'h00, 8'h00, 6'd0, 1'b0, 1'b0, 8'h0);
      exp_scan(t + 152, "re_strobe", 8'h00, 8'h01, 6'd0, 1'b0, 1'b1, 8'h10);
      exp_scan(t + 175, "re_disp0", 8'h01, 8'h00, 6'd0, 1'b0, 1'b1, 8'h17);
      wait_to(t + 150);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_to(t + 176);

      // Pulse generator with stop held
      bus.stop = 1'b1;
      for (int i = 0; i < 14; i++) begin
         bus.cond = csched[i];
         exp_pulse(cyc, "pulse", pexp[i]);
         step();
      end
      bus.stop = 1'b0;
      step();
      step();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
